card_shoe: RTL and testbench
============================

CARD_SHOE -- requirements
Module: card_shoe

Interface
REQ-001 Parameter LFSR_SEED, default 16'hACE1, the LFSR value loaded at reset; it SHALL be nonzero.
REQ-002 Parameter DECKS, default 1, the number of 52-card decks in the shoe; the legal range SHALL be 1..3.
REQ-003 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 draw_req  input  1  single-cycle request for one card.
REQ-006 shuffle  input  1  single-cycle request to refill the shoe to full.
REQ-007 script_en  input  1  1 = deal from the fixed test script instead of the random shoe.
REQ-008 card_valid  output  1  one-cycle strobe marking card_value as valid.
REQ-009 card_value  output  6  dealt card value: 2..10, or 11 for an ace.
REQ-010 cards_left  output  8  number of cards remaining in the shoe.
REQ-011 busy  output  1  high while a draw or shuffle is in progress.
REQ-012 empty_err  output  1  one-cycle strobe raised when a card is requested from an empty shoe.

Function
REQ-013 The shoe SHALL hold 13 rank counters, each 0..4*DECKS wide enough to count its rank; rank 0 = ace (value 11), ranks 1..8 = values 2..9, ranks 9..12 = value 10.
REQ-014 A 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11) SHALL advance every clock, independent of FSM state.
REQ-015 FSM states SHALL be IDLE, PICK, SCAN, DEAL and REFILL; busy SHALL be 1 in every state except IDLE.
REQ-016 In IDLE with shuffle=1, the FSM SHALL go to REFILL; REFILL SHALL set every counter to 4*DECKS and cards_left to 52*DECKS, then return to IDLE after 1 cycle.
REQ-017 In IDLE with draw_req=1, shuffle=0, script_en=0 and cards_left>0, the FSM SHALL go to PICK.
REQ-018 PICK SHALL compute the candidate rank from lfsr[3:0]: values 0..12 map directly; values 13, 14, 15 map to 0, 1, 2.
REQ-019 SCAN SHALL test one rank per cycle, starting at the candidate and incrementing modulo 13, until a nonzero counter is found; it SHALL test at most 13 ranks.
REQ-020 DEAL SHALL do the following in one cycle, then return to IDLE:
  - decrement the selected rank counter and cards_left;
  - drive card_value;
  - pulse card_valid.
REQ-021 Random draw latency SHALL be 3..15 cycles from the draw_req edge to card_valid.
REQ-022 With script_en=1 at draw_req, the card SHALL come from an 8-entry script, with card_valid 2 cycles after the request:
  - script order: 10, 8, 4, 2, 10, 11, 10, 10;
  - the 3-bit pointer SHALL advance and wrap from 7 to 0;
  - a scripted draw SHALL NOT change the counters or cards_left.
REQ-023 draw_req with script_en=0 and cards_left=0 SHALL pulse empty_err 1 cycle later, SHALL NOT pulse card_valid, and the FSM SHALL stay in IDLE.
REQ-024 draw_req and shuffle asserted in the same cycle: shuffle SHALL win and draw_req SHALL be dropped.
REQ-025 draw_req or shuffle arriving while busy=1 SHALL be ignored; no request queue SHALL exist.
REQ-026 card_value SHALL hold its last dealt value between strobes.
REQ-027 card_valid and empty_err SHALL never be high in the same cycle.

Reset
REQ-028 While reset=0, asynchronously:
  - FSM SHALL be in IDLE;
  - all counters SHALL be 4*DECKS;
  - cards_left SHALL be 52*DECKS;
  - LFSR SHALL equal LFSR_SEED;
  - script pointer SHALL be 0;
  - card_value, card_valid, empty_err and busy SHALL be 0.
REQ-029 Reset asserted mid-draw SHALL abort the draw with no card_valid, and the shoe SHALL come out of reset full.
REQ-030 After reset releases, the first request SHALL be accepted on the first rising edge.

Verification
REQ-031 Reset release, script_en=1, 4 draw_req pulses -> card_value 10, 8, 4, 2, each valid 2 cycles after its request; cards_left stays 52.
REQ-032 script_en=1, 9 draws -> 9th card = 10 (pointer wrapped to 0).
REQ-033 script_en=0, 52 draws -> exactly 4 of each rank, sum of card_value = 380, cards_left = 0; the 53rd draw -> empty_err pulse and no card_valid.
REQ-034 Empty shoe, shuffle pulse -> busy for 1 cycle, cards_left = 52; the next draw yields card_valid within 15 cycles.
REQ-035 draw_req and shuffle in the same cycle on a shoe with 40 left -> cards_left = 52 and no card_valid; a second draw_req while busy -> ignored.
REQ-036 reset=0 asserted 2 cycles into a random draw -> no card_valid, cards_left = 52, busy = 0.

Source files
------------

// File: rtl/card_shoe.sv
`default_nettype none
// ============================================================================
//  Module   : card_shoe
//  Purpose  : Blackjack card shoe. Holds DECKS x 52 cards as 13 rank
//             counters and deals a random card on request. The card is picked
//             by taking a candidate rank from a free-running LFSR and then
//             scanning forward to the next rank that still has cards. A fixed
//             8-card script can be dealt instead, for deterministic testing.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1  system clock, rising edge
//    reset      in   1  asynchronous reset, active low
//    draw_req   in   1  single-cycle request for one card
//    shuffle    in   1  single-cycle request to refill the shoe
//    script_en  in   1  1 = deal from the fixed script
//    card_valid out  1  one-cycle strobe, card_value is valid
//    card_value out  6  dealt value 2..10, 11 = ace (held between strobes)
//    cards_left out  8  cards remaining in the shoe
//    busy       out  1  draw or shuffle in progress
//    empty_err  out  1  one-cycle strobe, draw refused on an empty shoe
//  Parameters
//    LFSR_SEED  nonzero LFSR reset value
//    DECKS      number of decks, 1..3
// ============================================================================
module card_shoe #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          DECKS     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       draw_req,
  input  logic       shuffle,
  input  logic       script_en,
  output logic       card_valid,
  output logic [5:0] card_value,
  output logic [7:0] cards_left,
  output logic       busy,
  output logic       empty_err
);

  localparam int              CW        = $clog2(4 * DECKS + 1);
  localparam logic [CW-1:0]   RANK_FULL = CW'(4 * DECKS);
  localparam logic [7:0]      SHOE_FULL = 8'(52 * DECKS);
  // x^16 + x^14 + x^13 + x^11, right-shifting Galois form
  localparam logic [15:0]     LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PICK   = 3'd1,
    SCAN   = 3'd2,
    DEAL   = 3'd3,
    REFILL = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] rank_cnt [13];
  logic [15:0]   lfsr;
  logic [3:0]    rank;        // rank under test in SCAN, dealt rank in DEAL
  logic [3:0]    scanned;     // ranks already tested in this scan
  logic          scripted;    // current draw comes from the script
  logic [2:0]    script_ptr;

  // rank 0 = ace, ranks 1..8 = 2..9, ranks 9..12 = face cards and tens
  function automatic logic [5:0] rank_value(input logic [3:0] r);
    if (r == 4'd0)      return 6'd11;
    else if (r <= 4'd8) return 6'({2'b00, r} + 6'd1);
    else                return 6'd10;
  endfunction

  function automatic logic [5:0] script_value(input logic [2:0] p);
    case (p)
      3'd0:    return 6'd10;
      3'd1:    return 6'd8;
      3'd2:    return 6'd4;
      3'd3:    return 6'd2;
      3'd4:    return 6'd10;
      3'd5:    return 6'd11;
      default: return 6'd10;
    endcase
  endfunction

  // Free-running: advances every clock regardless of FSM state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr <= LFSR_SEED;
    else        lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      for (int i = 0; i < 13; i++) rank_cnt[i] <= RANK_FULL;
      cards_left <= SHOE_FULL;
      rank       <= 4'd0;
      scanned    <= 4'd0;
      scripted   <= 1'b0;
      script_ptr <= 3'd0;
      card_value <= 6'd0;
      card_valid <= 1'b0;
      empty_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      card_valid <= 1'b0;
      empty_err  <= 1'b0;
      case (state)
        IDLE: begin
          // shuffle has priority; a simultaneous draw_req is dropped
          if (shuffle) begin
            state <= REFILL;
            busy  <= 1'b1;
          end else if (draw_req) begin
            if (script_en) begin
              scripted <= 1'b1;
              state    <= PICK;
              busy     <= 1'b1;
            end else if (cards_left != 8'd0) begin
              scripted <= 1'b0;
              state    <= PICK;
              busy     <= 1'b1;
            end else begin
              empty_err <= 1'b1;
            end
          end
        end
        PICK: begin
          if (scripted) begin
            state <= DEAL;
          end else begin
            rank    <= (lfsr[3:0] > 4'd12) ? lfsr[3:0] - 4'd13 : lfsr[3:0];
            scanned <= 4'd0;
            state   <= SCAN;
          end
        end
        SCAN: begin
          if (rank_cnt[rank] != '0) begin
            state <= DEAL;
          end else if (scanned == 4'd12) begin
            // all 13 ranks empty: only reachable if counters and cards_left
            // ever disagree; give up rather than spin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            rank    <= (rank == 4'd12) ? 4'd0 : rank + 4'd1;
            scanned <= scanned + 4'd1;
          end
        end
        DEAL: begin
          card_valid <= 1'b1;
          state      <= IDLE;
          busy       <= 1'b0;
          if (scripted) begin
            card_value <= script_value(script_ptr);
            script_ptr <= script_ptr + 3'd1;
          end else begin
            card_value     <= rank_value(rank);
            rank_cnt[rank] <= rank_cnt[rank] - 1'b1;
            cards_left     <= cards_left - 8'd1;
          end
        end
        REFILL: begin
          for (int i = 0; i < 13; i++) rank_cnt[i] <= RANK_FULL;
          cards_left <= SHOE_FULL;
          state      <= IDLE;
          busy       <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_card_shoe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_card_shoe
//  Purpose  : Self-checking bench for card_shoe. Scripted draws come from a
//             table; random draws are checked against a shoe model holding
//             the remaining count of each card value.
//  Revision : 1.0  initial release
// ============================================================================
module tb_card_shoe;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       draw_req = 1'b0;
  logic       shuffle = 1'b0;
  logic       script_en = 1'b0;
  logic       card_valid;
  logic [5:0] card_value;
  logic [7:0] card_left_unused_guard;
  logic [7:0] cards_left;
  logic       busy;
  logic       empty_err;

  int checks = 0;
  int errors = 0;

  // shoe model: cards of each value still in the shoe, plus script position
  int vcnt [12];
  int left_m;
  int sp_m;
  int script_tab [8] = '{10, 8, 4, 2, 10, 11, 10, 10};

  typedef struct {
    bit scr;
    int exp_val;
    int exp_lat;
    int exp_left;
  } vec_t;
  vec_t tbl [9];

  card_shoe #(.LFSR_SEED(16'hACE1), .DECKS(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .draw_req   (draw_req),
    .shuffle    (shuffle),
    .script_en  (script_en),
    .card_valid (card_valid),
    .card_value (card_value),
    .cards_left (cards_left),
    .busy       (busy),
    .empty_err  (empty_err)
  );

  assign card_left_unused_guard = cards_left;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (card_valid && empty_err) begin
      errors++;
      $display("FAIL valid_and_empty: got both high, expected exclusive");
    end
  end

  task automatic model_fill();
    for (int v = 0; v < 12; v++) vcnt[v] = (v >= 2) ? 4 : 0;
    vcnt[10] = 16;
    left_m = 52;
  endtask

  // Called at a negedge; returns at a negedge. lat = clock edges from the
  // edge that sampled draw_req to the edge that raised card_valid.
  task automatic do_draw(input bit scr, output bit got, output int val,
                         output int lat, output bit emp);
    script_en = scr;
    draw_req  = 1'b1;
    got = 0; val = -1; lat = -1; emp = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) draw_req = 1'b0;
      if (empty_err) emp = 1;
      if (card_valid) begin
        got = 1; val = int'(card_value); lat = k - 1;
        break;
      end
    end
  endtask

  task automatic do_shuffle();
    shuffle = 1'b1;
    @(negedge clk);
    shuffle = 1'b0;
    chk("shuffle_busy", int'(busy), 1);
    @(negedge clk);
    chk("shuffle_idle", int'(busy), 0);
    chk("shuffle_left", int'(cards_left), 52);
    model_fill();
  endtask

  task automatic random_draw_checked(input string tag);
    bit got, emp;
    int val, lat;
    do_draw(1'b0, got, val, lat, emp);
    if (left_m == 0) begin
      chk({tag, "_empty_err"}, int'(emp), 1);
      chk({tag, "_empty_noval"}, int'(got), 0);
    end else begin
      chk({tag, "_valid"}, int'(got), 1);
      chk({tag, "_lat_range"}, int'(lat >= 3 && lat <= 15), 1);
      chk({tag, "_val_avail"}, int'(val >= 2 && val <= 11 && vcnt[(val >= 2 && val <= 11) ? val : 0] > 0), 1);
      if (val >= 2 && val <= 11 && vcnt[val] > 0) vcnt[val]--;
      left_m--;
    end
    chk({tag, "_left"}, int'(cards_left), left_m);
  endtask

  task automatic script_draw_checked();
    bit got, emp;
    int val, lat;
    do_draw(1'b1, got, val, lat, emp);
    chk("rs_val", val, script_tab[sp_m]);
    chk("rs_lat", lat, 2);
    chk("rs_left", int'(cards_left), left_m);
    sp_m = (sp_m + 1) % 8;
  endtask

  initial begin
    bit got, emp;
    int val, lat, sum, held;
    int dealt [12];

    tbl[0] = '{1, 10, 2, 52};
    tbl[1] = '{1,  8, 2, 52};
    tbl[2] = '{1,  4, 2, 52};
    tbl[3] = '{1,  2, 2, 52};
    tbl[4] = '{1, 10, 2, 52};
    tbl[5] = '{1, 11, 2, 52};
    tbl[6] = '{1, 10, 2, 52};
    tbl[7] = '{1, 10, 2, 52};
    tbl[8] = '{1, 10, 2, 52};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(card_valid), 0);
    chk("rst_empty", int'(empty_err), 0);
    chk("rst_value", int'(card_value), 0);
    chk("rst_left", int'(cards_left), 52);
    model_fill();
    sp_m = 0;

    // scripted draws, first one issued on the very first edge after release
    reset = 1'b1;
    for (int i = 0; i < 9; i++) begin
      do_draw(tbl[i].scr, got, val, lat, emp);
      chk("tbl_valid", int'(got), 1);
      chk("tbl_value", val, tbl[i].exp_val);
      chk("tbl_lat", lat, tbl[i].exp_lat);
      chk("tbl_left", int'(cards_left), tbl[i].exp_left);
      sp_m = (sp_m + 1) % 8;
    end

    // card_value holds between strobes
    held = int'(card_value);
    repeat (3) @(negedge clk);
    chk("value_hold", int'(card_value), held);

    // empty the shoe with 52 random draws
    for (int v = 0; v < 12; v++) dealt[v] = 0;
    sum = 0;
    for (int i = 0; i < 52; i++) begin
      do_draw(1'b0, got, val, lat, emp);
      checks++;
      if (!got || lat < 3 || lat > 15 || val < 2 || val > 11) begin
        errors++;
        $display("FAIL deal52_draw: got valid=%0d lat=%0d val=%0d, expected valid lat 3..15 val 2..11", got, lat, val);
      end else begin
        dealt[val]++;
        sum += val;
      end
    end
    for (int v = 2; v <= 11; v++) chk("deal52_count", dealt[v], (v == 10) ? 16 : 4);
    chk("deal52_sum", sum, 380);
    chk("deal52_left", int'(cards_left), 0);
    do_draw(1'b0, got, val, lat, emp);
    chk("draw53_empty_err", int'(emp), 1);
    chk("draw53_novalid", int'(got), 0);
    chk("draw53_idle", int'(busy), 0);

    // refill, then draw from the refilled shoe
    do_shuffle();
    random_draw_checked("post_shuffle");
    for (int i = 0; i < 11; i++) random_draw_checked("to40");
    chk("at40_left", int'(cards_left), 40);

    // draw_req + shuffle together, then a draw_req while busy
    script_en = 1'b0;
    draw_req = 1'b1; shuffle = 1'b1;
    @(negedge clk);
    shuffle = 1'b0;
    chk("both_busy", int'(busy), 1);
    @(negedge clk);
    draw_req = 1'b0;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      if (card_valid) got = 1;
      @(negedge clk);
    end
    chk("both_novalid", int'(got), 0);
    chk("both_left", int'(cards_left), 52);
    model_fill();

    // randomized mix against the shoe model
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: random_draw_checked("rnd");
        6, 7:             script_draw_checked();
        8:                do_shuffle();
        default: begin
          script_en = 1'($urandom_range(0, 1));
          repeat ($urandom_range(1, 3)) @(negedge clk);
        end
      endcase
    end

    // reset two cycles into a random draw
    do_shuffle();
    random_draw_checked("pre_abort");
    script_en = 1'b0;
    draw_req = 1'b1;
    @(negedge clk);
    draw_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_left", int'(cards_left), 52);
    got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 2) reset = 1'b1;
      if (card_valid) got = 1;
    end
    chk("abort_novalid", int'(got), 0);
    chk("abort_idle", int'(busy), 0);
    chk("abort_left_after", int'(cards_left), 52);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
